// File: rtl/bf_program_uploader.sv
// Streams a ROM program image to the processor as 8N1 UART frames while holding loading high, then waits for done.
// First start bit appears SETUP_CYCLES+3 cycles after start; 10*BIT_PERIOD+2 cycles per byte; start is ignored while busy.
module bf_program_uploader #(
  parameter int CODE_SIZE_LOG = 9,
  parameter int BIT_PERIOD    = 12,
  parameter int SETUP_CYCLES  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CODE_SIZE_LOG:0]   prog_len,
  output logic [CODE_SIZE_LOG-1:0] rom_addr,
  input  logic [7:0]               rom_data,
  output logic                     loading,
  output logic                     tx,
  input  logic                     done,
  output logic                     busy,
  output logic                     finished
);

  localparam int BW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int IW = CODE_SIZE_LOG + 1;

  typedef enum logic [2:0] {IDLE, SETUP, FETCH, LATCH, SEND, RUN} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   len_q;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_inc;
  logic [SW-1:0]   setup_cnt;
  logic [BW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [1:0]      run_cnt;
  logic            setup_end;
  logic            bit_end;
  logic            frame_end;
  logic            last_byte;
  logic            done_ok;

  assign idx_inc   = idx + IW'(1);
  assign setup_end = (setup_cnt == SW'(SETUP_CYCLES - 1));
  assign bit_end   = (baud_cnt == BW'(BIT_PERIOD - 1));
  assign frame_end = bit_end && (bit_cnt == 4'd9);
  assign last_byte = (idx_inc == len_q);
  assign done_ok   = (run_cnt == 2'd2) && done;
  assign rom_addr  = idx[CODE_SIZE_LOG-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (setup_end) state_nxt = (len_q != '0) ? FETCH : RUN;
      FETCH:   state_nxt = LATCH;
      LATCH:   state_nxt = SEND;
      SEND:    if (frame_end) state_nxt = last_byte ? RUN : FETCH;
      RUN:     if (done_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx is registered from the SEND counters, so the line trails the FSM by one cycle;
  // loading is therefore released on the first RUN edge, which is when the stop bit ends on the wire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      idx       <= '0;
      setup_cnt <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      run_cnt   <= '0;
      tx        <= 1'b1;
      loading   <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start) begin
            len_q     <= prog_len;
            idx       <= '0;
            setup_cnt <= '0;
            run_cnt   <= '0;
            busy      <= 1'b1;
            loading   <= 1'b1;
          end
        end
        SETUP: begin
          tx        <= 1'b1;
          setup_cnt <= setup_cnt + SW'(1);
          if (setup_end && (len_q == '0)) loading <= 1'b0;
        end
        FETCH: tx <= 1'b1;
        LATCH: begin
          tx       <= 1'b1;
          shreg    <= rom_data;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
        SEND: begin
          if (bit_cnt == 4'd0)      tx <= 1'b0;
          else if (bit_cnt == 4'd9) tx <= 1'b1;
          else                      tx <= shreg[0];
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt != 4'd0) shreg <= {1'b0, shreg[7:1]};
            if (frame_end) begin
              bit_cnt <= '0;
              // The final index is held so rom_addr never wraps back to 0 after a full-size image.
              if (!last_byte) idx <= idx_inc;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        RUN: begin
          tx      <= 1'b1;
          loading <= 1'b0;
          // The stale-done guard counts only cycles where loading is already low.
          if (!loading && (run_cnt != 2'd2)) run_cnt <= run_cnt + 2'd1;
          if (done_ok) begin
            finished <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_program_uploader.sv
// Directed bench for bf_program_uploader with a cycle-level timing model of the upload waveform.
module tb_bf_program_uploader;

  localparam int CSL  = 9;
  localparam int BP   = 12;
  localparam int SC   = 16;
  localparam int FR   = 10 * BP + 2;
  localparam int NONE = 32'h7fff_ffff;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [CSL:0]   prog_len;
  logic [CSL-1:0] rom_addr;
  logic [7:0]     rom_data = 8'h00;
  logic           loading;
  logic           tx;
  logic           done;
  logic           busy;
  logic           finished;

  logic [7:0] rom [512];
  logic [7:0] lit [5];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model state
  int m_act    = 0;
  int m_t      = 0;
  int m_len    = 0;
  int m_lfall  = 0;
  int m_fin    = NONE;

  bf_program_uploader #(.CODE_SIZE_LOG(CSL), .BIT_PERIOD(BP), .SETUP_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .rom_addr(rom_addr),
    .rom_data(rom_data), .loading(loading), .tx(tx), .done(done), .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s @cyc %0d: wait bound expired", name, cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after edge n, derived from the upload timing rules.
  always @(negedge clk) begin
    int n, e_tx, e_ld, e_busy, e_fin, e_addr, rel, k, off, b, cnt;
    n = cyc;
    if (!reset) m_act = 0;
    e_tx = 1; e_ld = 0; e_busy = 0; e_fin = 0; e_addr = 0;
    if (m_act != 0) begin
      e_busy = (n < m_fin) ? 1 : 0;
      e_fin  = (n == m_fin) ? 1 : 0;
      e_ld   = (n < m_lfall) ? 1 : 0;
      if (m_len > 0 && n >= m_t + SC + 3) begin
        rel = n - (m_t + SC + 3);
        k = rel / FR;
        off = rel % FR;
        if (k < m_len && off < 10 * BP) begin
          b = off / BP;
          if (b == 0) e_tx = 0;
          else if (b == 9) e_tx = 1;
          else e_tx = int'(rom[k][b-1]);
        end
      end
      if (m_len > 0) begin
        cnt = (n >= m_t + SC + FR) ? ((n - (m_t + SC + FR)) / FR + 1) : 0;
        e_addr = (cnt < m_len - 1) ? cnt : m_len - 1;
      end
    end
    chk("tx", int'(tx), e_tx);
    chk("loading", int'(loading), e_ld);
    chk("busy", int'(busy), e_busy);
    chk("finished", int'(finished), e_fin);
    chk("rom_addr", int'(rom_addr), e_addr);
    if (m_act != 0 && m_fin == NONE && n >= m_lfall + 2 && done) m_fin = n + 1;
    if (reset && start && (m_act == 0 || n >= m_fin)) begin
      m_act   = 1;
      m_t     = n + 1;
      m_len   = int'(prog_len);
      m_fin   = NONE;
      m_lfall = (m_len == 0) ? m_t + SC : m_t + SC + 3 + m_len * FR - 2;
    end
  end

  task automatic pulse_start(input int len, output int t_acc);
    prog_len = (CSL+1)'(len);
    t_acc = cyc + 1;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_tx_low(input int bound, output int n_first);
    n_first = -1;
    for (int i = 0; i < bound; i++) begin
      if (!tx) begin
        n_first = cyc;
        break;
      end
      tick;
    end
    if (n_first < 0) timeout("wait_start_bit");
  endtask

  task automatic decode(input int base, input int pulse_bit, output logic [7:0] d,
                        output logic sb, output logic pb);
    d = 8'h00; sb = 1'b1; pb = 1'b0;
    for (int b = 0; b < 10; b++) begin
      while (cyc < base + BP / 2 + BP * b) tick;
      start = (b == pulse_bit);
      if (b == 0) sb = tx;
      else if (b == 9) pb = tx;
      else d[b-1] = tx;
    end
    start = 1'b0;
  endtask

  task automatic wait_sig(input string name, input int bound, input logic want_fin);
    int seen;
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (want_fin ? finished : !loading) begin
        seen = 1;
        break;
      end
      tick;
    end
    if (seen == 0) timeout(name);
  endtask

  initial begin
    int t_acc, n_first, extra, t_fall;
    logic [7:0] d;
    logic sb, pb;

    lit[0] = 8'h2B; lit[1] = 8'h5B; lit[2] = 8'h2D; lit[3] = 8'h5D; lit[4] = 8'h2E;
    for (int i = 0; i < 512; i++) rom[i] = 8'(i * 7 + 3);
    reset = 1'b0; start = 1'b0; done = 1'b0; prog_len = '0;
    repeat (3) tick;
    reset = 1'b1;
    repeat (100) tick;
    chk("idle_rom_addr", int'(rom_addr), 0);

    // five-byte program "+[-]." with stray start pulses during SEND and RUN
    for (int i = 0; i < 5; i++) rom[i] = lit[i];
    pulse_start(5, t_acc);
    wait_tx_low(100, n_first);
    chk("first_start_latency", n_first - t_acc, 19);
    for (int k = 0; k < 5; k++) begin
      decode(n_first + FR * k, (k == 1) ? 4 : -1, d, sb, pb);
      chk("frame_start_bit", int'(sb), 0);
      chk("frame_stop_bit", int'(pb), 1);
      chk("frame_byte", int'(d), int'(lit[k]));
    end
    wait_sig("wait_loading_fall", 200, 1'b0);
    chk("loading_fall_offset", cyc - n_first, 4 * FR + 120);
    start = 1'b1; tick; start = 1'b0;
    repeat (19) tick;
    done = 1'b1;
    wait_sig("wait_finished_5", 20, 1'b1);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (finished) extra++;
    end
    chk("finished_single_pulse", extra, 0);
    chk("busy_after_finish", int'(busy), 0);
    done = 1'b0;

    // empty program with done already high
    repeat (5) tick;
    done = 1'b1;
    pulse_start(0, t_acc);
    wait_sig("wait_finished_0", 40, 1'b1);
    chk("len0_finish_latency", cyc - t_acc, 19);
    done = 1'b0;

    // full-size image
    repeat (5) tick;
    for (int i = 0; i < 512; i++) rom[i] = 8'(i * 7 + 3);
    pulse_start(512, t_acc);
    t_fall = -1;
    for (int i = 0; i < 70000; i++) begin
      tick;
      start = ((cyc % 1000) == 500);
      if (!loading) begin
        t_fall = cyc;
        break;
      end
    end
    start = 1'b0;
    if (t_fall < 0) timeout("wait_loading_fall_512");
    chk("len512_loading_fall", cyc - t_acc, SC + 3 + 512 * FR - 2);
    chk("len512_last_addr", int'(rom_addr), 511);
    done = 1'b1;
    wait_sig("wait_finished_512", 20, 1'b1);
    done = 1'b0;

    // reset in the middle of the third frame, then a clean restart
    repeat (5) tick;
    for (int i = 0; i < 5; i++) rom[i] = lit[i];
    pulse_start(5, t_acc);
    while (cyc < t_acc + 19 + 2 * FR + 3 * BP + 5) tick;
    #2 reset = 1'b0;
    #1;
    chk("async_reset_tx", int'(tx), 1);
    chk("async_reset_loading", int'(loading), 0);
    chk("async_reset_busy", int'(busy), 0);
    repeat (3) tick;
    reset = 1'b1;
    tick;
    pulse_start(5, t_acc);
    wait_tx_low(100, n_first);
    chk("restart_latency", n_first - t_acc, 19);
    decode(n_first, -1, d, sb, pb);
    chk("restart_first_byte", int'(d), 8'h2B);
    wait_sig("wait_loading_fall_restart", 1000, 1'b0);
    done = 1'b1;
    wait_sig("wait_finished_restart", 20, 1'b1);
    done = 1'b0;
    repeat (5) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
